// File: rtl/lab4d_pkg.sv
// rtl/lab4d_pkg.sv - shared constants, state encodings and lane helpers for the LAB4D serial arbiter
// Purpose: chip count, word length, broadcast select code, default test-pattern
//          address, FSM encodings and select-decode helpers.
// Optional feature macro used by this slice: LAB4D_SHOUT_READBACK_EN
package lab4d_pkg;

  localparam int          NUM_LAB       = 12;
  localparam int          WORD_BITS     = 24;
  localparam logic [3:0]  LAB_SEL_BCAST = 4'hF;
  localparam logic [11:0] TP_ADDR_DEF   = 12'h000;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_LOAD   = 3'd1,
    ARB_RUN    = 3'd2,
    ARB_DONE   = 3'd3,
    ARB_REJECT = 3'd4
  } arb_state_t;

  typedef enum logic [2:0] {
    SH_IDLE  = 3'd0,
    SH_SLO   = 3'd1,
    SH_SHI   = 3'd2,
    SH_LATCH = 3'd3,
    SH_GAP   = 3'd4
  } sh_state_t;

  // 0..NUM_LAB-1 address one chip, LAB_SEL_BCAST addresses all of them.
  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel == LAB_SEL_BCAST) || (int'(sel) < NUM_LAB);
  endfunction

  function automatic logic [NUM_LAB-1:0] lane_mask(input logic [3:0] sel);
    logic [NUM_LAB-1:0] m;
    m = '0;
    if (sel == LAB_SEL_BCAST) begin
      m = '1;
    end else if (int'(sel) < NUM_LAB) begin
      m[sel] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lab4d_serial_arbiter_if.sv
// rtl/lab4d_serial_arbiter_if.sv - request/acknowledge bundle for the two LAB4D write requesters
// Purpose: groups the user-write and test-pattern handshakes.
// Ports (signals):
//   user_req/user_sel/user_word  requester -> arbiter, held until user_ack
//   user_ack/user_err            arbiter -> requester, one-cycle pulses
//   tp_req/tp_data               requester -> arbiter, held until tp_ack
//   tp_ack                       arbiter -> requester, one-cycle pulse
// Modports: master = requester side, slave = arbiter side.
interface lab4d_serial_arbiter_if;
  import lab4d_pkg::*;

  logic                 user_req;
  logic [3:0]           user_sel;
  logic [WORD_BITS-1:0] user_word;
  logic                 user_ack;
  logic                 user_err;
  logic                 tp_req;
  logic [11:0]          tp_data;
  logic                 tp_ack;

  modport master (
    output user_req, user_sel, user_word, tp_req, tp_data,
    input  user_ack, user_err, tp_ack
  );

  modport slave (
    input  user_req, user_sel, user_word, tp_req, tp_data,
    output user_ack, user_err, tp_ack
  );

endinterface

// File: rtl/lab4d_serial_shifter.sv
// rtl/lab4d_serial_shifter.sv - SIN/SCLK/PCLK sequencer for one 24-bit LAB4D serial write
// Purpose: shifts word_i MSB-first with SCLK phases of H = prescale_i+1 cycles,
//          then PCLK for 2H and a quiet gap of H; optionally captures SHOUT.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   start_i            one-cycle start; word_i/sel_i/prescale_i held stable by caller
//   word_i, sel_i      serial word and LAB select (15 = broadcast)
//   prescale_i         SCLK half-period minus one
//   shout_i            per-LAB serial readback
//   done_o             high in the last gap cycle
//   sin_o/sclk_o/pclk_o  per-LAB pins, unselected lanes held at 0
//   capture_o          captured SHOUT word (0 unless LAB4D_SHOUT_READBACK_EN)
module lab4d_serial_shifter
  import lab4d_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [3:0]           sel_i,
  input  logic [7:0]           prescale_i,
  input  logic [NUM_LAB-1:0]   shout_i,
  output logic                 done_o,
  output logic [NUM_LAB-1:0]   sin_o,
  output logic [NUM_LAB-1:0]   sclk_o,
  output logic [NUM_LAB-1:0]   pclk_o,
  output logic [WORD_BITS-1:0] capture_o
);

  sh_state_t          r_state;
  sh_state_t          w_next;
  logic [8:0]         r_cnt;
  logic [4:0]         r_bit;
  logic               w_phase_end;
  logic [NUM_LAB-1:0] w_mask;
  logic               w_sin;
  logic               w_sclk;
  logic               w_pclk;

  assign w_phase_end = (r_cnt == 9'd0);
  assign w_mask      = lane_mask(sel_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= SH_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SH_IDLE:  if (start_i)     w_next = SH_SLO;
      SH_SLO:   if (w_phase_end) w_next = SH_SHI;
      SH_SHI:   if (w_phase_end) w_next = (r_bit == 5'd0) ? SH_LATCH : SH_SLO;
      SH_LATCH: if (w_phase_end) w_next = SH_GAP;
      SH_GAP:   if (w_phase_end) w_next = SH_IDLE;
      default:                   w_next = SH_IDLE;
    endcase
  end

  always_comb begin
    w_sin  = 1'b0;
    w_sclk = 1'b0;
    w_pclk = 1'b0;
    case (r_state)
      SH_SLO:   w_sin  = word_i[r_bit];
      SH_SHI: begin
        w_sin  = word_i[r_bit];
        w_sclk = 1'b1;
      end
      SH_LATCH: w_pclk = 1'b1;
      default: ;
    endcase
  end

  assign done_o = (r_state == SH_GAP) && w_phase_end;
  assign sin_o  = w_mask & {NUM_LAB{w_sin}};
  assign sclk_o = w_mask & {NUM_LAB{w_sclk}};
  assign pclk_o = w_mask & {NUM_LAB{w_pclk}};

  // Phase counter counts down to 0; each phase reloads it with the length of
  // the phase being entered (H-1, or 2H-1 for the PCLK pulse).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (r_state == SH_IDLE) begin
      r_cnt <= {1'b0, prescale_i};
      r_bit <= 5'(WORD_BITS - 1);
    end else if (w_phase_end) begin
      if (r_state == SH_SHI && r_bit == 5'd0) begin
        r_cnt <= {prescale_i, 1'b1};
      end else begin
        r_cnt <= {1'b0, prescale_i};
      end
      if (r_state == SH_SHI && r_bit != 5'd0) begin
        r_bit <= r_bit - 5'd1;
      end
    end else begin
      r_cnt <= r_cnt - 9'd1;
    end
  end

`ifdef LAB4D_SHOUT_READBACK_EN
  logic [WORD_BITS-1:0] r_cap;
  logic [3:0]           w_rb_lane;

  // Broadcast writes read back through LAB0.
  assign w_rb_lane = (sel_i == LAB_SEL_BCAST) ? 4'd0 : sel_i;

  // First SHI cycle is the one where the counter still holds its reload value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cap <= '0;
    end else if (r_state == SH_SHI && r_cnt == {1'b0, prescale_i}) begin
      r_cap <= {r_cap[WORD_BITS-2:0], shout_i[w_rb_lane]};
    end
  end

  assign capture_o = r_cap;
`else
  logic w_unused_shout;
  assign w_unused_shout = ^shout_i;
  assign capture_o      = '0;
`endif

endmodule

// File: rtl/lab4d_serial_arbiter.sv
// rtl/lab4d_serial_arbiter.sv - round-robin arbiter sequencing serial writes into the LAB4D chips
// Purpose: grants the user-write or test-pattern requester, latches word/select/
//          prescale at grant, runs the serial shifter and returns ack/err pulses.
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   prescale_i           SCLK half-period minus one, sampled at grant
//   req_if (slave)       user and test-pattern request/ack handshakes
//   busy_o               high from the cycle after grant through the ack cycle
//   SIN/SCLK/PCLK        per-LAB serial pins
//   SHOUT                per-LAB serial readback
//   readback_o/_valid_o  captured SHOUT word and its update strobe
// Optional feature macro: LAB4D_SHOUT_READBACK_EN (SHOUT readback capture).
module lab4d_serial_arbiter
  import lab4d_pkg::*;
#(
  parameter logic [11:0] TP_ADDR = TP_ADDR_DEF
)
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            prescale_i,
  lab4d_serial_arbiter_if.slave req_if,
  output logic                  busy_o,
  output logic [NUM_LAB-1:0]    SIN,
  output logic [NUM_LAB-1:0]    SCLK,
  output logic [NUM_LAB-1:0]    PCLK,
  input  logic [NUM_LAB-1:0]    SHOUT,
  output logic [WORD_BITS-1:0]  readback_o,
  output logic                  readback_valid_o
);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [WORD_BITS-1:0] r_word;
  logic [3:0]           r_sel;
  logic [7:0]           r_p;
  logic                 r_last_tp;
  logic                 r_post_ack;
  logic                 w_user_req;
  logic                 w_tp_req;
  logic                 w_grant_user;
  logic                 w_grant_tp;
  logic                 w_start;
  logic                 w_sh_done;
  logic [WORD_BITS-1:0] w_cap;

  // A requester may still hold req in the cycle right after its ack, so the
  // one just served is ignored for that single cycle.
  assign w_user_req   = req_if.user_req & ~(r_post_ack & ~r_last_tp);
  assign w_tp_req     = req_if.tp_req   & ~(r_post_ack &  r_last_tp);
  assign w_grant_user = w_user_req & (~w_tp_req | r_last_tp);
  assign w_grant_tp   = w_tp_req & ~w_grant_user;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_user) begin
          w_next = sel_legal(req_if.user_sel) ? ARB_LOAD : ARB_REJECT;
        end else if (w_grant_tp) begin
          w_next = ARB_LOAD;
        end
      end
      ARB_LOAD:   w_next = ARB_RUN;
      ARB_RUN:    if (w_sh_done) w_next = ARB_DONE;
      ARB_DONE:   w_next = ARB_IDLE;
      ARB_REJECT: w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy_o          = (r_state != ARB_IDLE);
    w_start         = (r_state == ARB_LOAD);
    req_if.user_ack = ((r_state == ARB_DONE) && !r_last_tp) || (r_state == ARB_REJECT);
    req_if.user_err = (r_state == ARB_REJECT);
    req_if.tp_ack   = (r_state == ARB_DONE) && r_last_tp;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_word     <= '0;
      r_sel      <= '0;
      r_p        <= '0;
      r_last_tp  <= 1'b1;
      r_post_ack <= 1'b0;
    end else begin
      r_post_ack <= (r_state == ARB_DONE) || (r_state == ARB_REJECT);
      if (r_state == ARB_IDLE) begin
        if (w_grant_user) begin
          r_word    <= req_if.user_word;
          r_sel     <= req_if.user_sel;
          r_p       <= prescale_i;
          r_last_tp <= 1'b0;
        end else if (w_grant_tp) begin
          r_word    <= {TP_ADDR, req_if.tp_data};
          r_sel     <= LAB_SEL_BCAST;
          r_p       <= prescale_i;
          r_last_tp <= 1'b1;
        end
      end
    end
  end

  lab4d_serial_shifter u_shifter (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (w_start),
    .word_i     (r_word),
    .sel_i      (r_sel),
    .prescale_i (r_p),
    .shout_i    (SHOUT),
    .done_o     (w_sh_done),
    .sin_o      (SIN),
    .sclk_o     (SCLK),
    .pclk_o     (PCLK),
    .capture_o  (w_cap)
  );

`ifdef LAB4D_SHOUT_READBACK_EN
  logic [WORD_BITS-1:0] r_readback;

  // Loaded on the edge into DONE so it is valid alongside the ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_readback <= '0;
    end else if (r_state == ARB_RUN && w_sh_done) begin
      r_readback <= w_cap;
    end
  end

  assign readback_o       = r_readback;
  assign readback_valid_o = (r_state == ARB_DONE);
`else
  logic w_unused_cap;
  assign w_unused_cap     = ^w_cap;
  assign readback_o       = '0;
  assign readback_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_lab4d_serial_arbiter.sv
// tb/tb_lab4d_serial_arbiter.sv - directed self-checking bench for lab4d_serial_arbiter
module tb_lab4d_serial_arbiter;
  import lab4d_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  prescale_i = 8'd0;
  logic        busy_o;
  logic [11:0] SIN;
  logic [11:0] SCLK;
  logic [11:0] PCLK;
  logic [11:0] SHOUT = 12'h000;
  logic [23:0] readback_o;
  logic        readback_valid_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] shout_pat = 24'h123456;

  lab4d_serial_arbiter_if rif();

  lab4d_serial_arbiter dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .prescale_i       (prescale_i),
    .req_if           (rif),
    .busy_o           (busy_o),
    .SIN              (SIN),
    .SCLK             (SCLK),
    .PCLK             (PCLK),
    .SHOUT            (SHOUT),
    .readback_o       (readback_o),
    .readback_valid_o (readback_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Expected pin levels in cycle n after grant (n=1 is LOAD), H = P+1.
  task automatic model(input int n, input int h, input logic [23:0] w,
                       output logic s, output logic c, output logic p, output int b);
    int k;
    k = n - 2;
    s = 1'b0; c = 1'b0; p = 1'b0; b = -1;
    if (k >= 0 && k < 48 * h) begin
      b = 23 - k / (2 * h);
      s = w[b];
      c = ((k % (2 * h)) >= h);
    end else if (k >= 48 * h && k < 50 * h) begin
      p = 1'b1;
    end
  endtask

  // Called at the negedge of the cycle in which the request is first seen.
  task automatic wait_check(input bit is_tp, input int h, input logic [23:0] w,
                            input logic [11:0] mask, input int rb_lane);
    int          last;
    logic        s, c, p;
    int          b;
    logic [23:0] exp_rb;
    logic [7:0]  p_saved;
    last    = 2 + 51 * h;
    p_saved = prescale_i;
    exp_rb  = (rb_lane == 5) ? shout_pat : ~shout_pat;
    check("busy_at_grant", {31'd0, busy_o}, 32'd0);
    for (int n = 1; n <= last; n++) begin
      tick();
      model(n, h, w, s, c, p, b);
      SHOUT = (b < 0) ? 12'h000 : (shout_pat[b] ? 12'h020 : 12'hFDF);
      if (n == 10) prescale_i = ~p_saved;
      check($sformatf("sin@%0d", n),  {20'd0, SIN},  {20'd0, s ? mask : 12'h000});
      check($sformatf("sclk@%0d", n), {20'd0, SCLK}, {20'd0, c ? mask : 12'h000});
      check($sformatf("pclk@%0d", n), {20'd0, PCLK}, {20'd0, p ? mask : 12'h000});
      check($sformatf("busy@%0d", n), {31'd0, busy_o}, 32'd1);
      check($sformatf("user_ack@%0d", n), {31'd0, rif.user_ack}, {31'd0, (!is_tp && n == last)});
      check($sformatf("tp_ack@%0d", n), {31'd0, rif.tp_ack}, {31'd0, (is_tp && n == last)});
      check($sformatf("user_err@%0d", n), {31'd0, rif.user_err}, 32'd0);
`ifdef LAB4D_SHOUT_READBACK_EN
      check($sformatf("rb_valid@%0d", n), {31'd0, readback_valid_o}, {31'd0, (n == last)});
      if (n == last) check("readback", {8'd0, readback_o}, {8'd0, exp_rb});
`else
      check($sformatf("rb_valid@%0d", n), {31'd0, readback_valid_o}, 32'd0);
      check($sformatf("readback@%0d", n), {8'd0, readback_o}, 32'd0);
`endif
      if (n == last) begin
        if (is_tp) rif.tp_req = 1'b0;
        else       rif.user_req = 1'b0;
      end
    end
    prescale_i = p_saved;
    SHOUT      = 12'h000;
    tick();
    check("busy_after_ack", {31'd0, busy_o}, 32'd0);
    check("acks_after_ack", {30'd0, rif.user_ack, rif.tp_ack}, 32'd0);
  endtask

  initial begin
    rif.user_req  = 1'b0;
    rif.user_sel  = 4'd0;
    rif.user_word = 24'd0;
    rif.tp_req    = 1'b0;
    rif.tp_data   = 12'd0;

    // Reset state
    tick();
    tick();
    check("rst_sin",  {20'd0, SIN},  32'd0);
    check("rst_sclk", {20'd0, SCLK}, 32'd0);
    check("rst_pclk", {20'd0, PCLK}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_acks", {29'd0, rif.user_ack, rif.user_err, rif.tp_ack}, 32'd0);
    check("rst_rb",   {7'd0, readback_valid_o, readback_o}, 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Tie after reset: user wins (lane 3, P=0), then test pattern broadcast
    prescale_i    = 8'd0;
    rif.user_sel  = 4'd3;
    rif.user_word = 24'hA5C3F0;
    rif.user_req  = 1'b1;
    rif.tp_data   = 12'h5A5;
    rif.tp_req    = 1'b1;
    wait_check(1'b0, 1, 24'hA5C3F0, 12'h008, 3);
    wait_check(1'b1, 1, {12'h000, 12'h5A5}, 12'hFFF, 0);
    tick();

    // Illegal select: immediate ack+err, no pin activity
    rif.user_sel  = 4'd13;
    rif.user_word = 24'hFFFFFF;
    rif.user_req  = 1'b1;
    tick();
    check("ill_ack",  {31'd0, rif.user_ack}, 32'd1);
    check("ill_err",  {31'd0, rif.user_err}, 32'd1);
    check("ill_busy", {31'd0, busy_o}, 32'd1);
    check("ill_pins", {8'd0, SIN | SCLK | PCLK}, 32'd0);
    check("ill_tpack", {31'd0, rif.tp_ack}, 32'd0);
    rif.user_req = 1'b0;
    tick();
    check("ill_ack_off",  {30'd0, rif.user_ack, rif.user_err}, 32'd0);
    check("ill_busy_off", {31'd0, busy_o}, 32'd0);
    check("ill_pins2",    {8'd0, SIN | SCLK | PCLK}, 32'd0);
    tick();

    // Tie with user last served: test pattern first, then user broadcast, P=1
    prescale_i    = 8'd1;
    rif.user_sel  = 4'd15;
    rif.user_word = 24'h0F0F0F;
    rif.user_req  = 1'b1;
    rif.tp_data   = 12'hC3C;
    rif.tp_req    = 1'b1;
    wait_check(1'b1, 2, {12'h000, 12'hC3C}, 12'hFFF, 0);
    wait_check(1'b0, 2, 24'h0F0F0F, 12'hFFF, 0);
    tick();

    // P=3 on lane 7: ack 206 cycles after grant
    prescale_i    = 8'd3;
    rif.user_sel  = 4'd7;
    rif.user_word = 24'h3C5A96;
    rif.user_req  = 1'b1;
    wait_check(1'b0, 4, 24'h3C5A96, 12'h080, 7);
    tick();

    // Lane 5 with SHOUT pattern on lane 5
    prescale_i    = 8'd0;
    rif.user_sel  = 4'd5;
    rif.user_word = 24'h654321;
    rif.user_req  = 1'b1;
    wait_check(1'b0, 1, 24'h654321, 12'h020, 5);
    tick();

    // Reset during bit 10 of a lane-2 write
    rif.user_sel  = 4'd2;
    rif.user_word = 24'hFFFFFF;
    rif.user_req  = 1'b1;
    for (int n = 1; n <= 28; n++) tick();
    check("mid_sin_bit10", {20'd0, SIN}, 32'h004);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_pins", {8'd0, SIN | SCLK | PCLK}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    rif.user_req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rst_hold_pins", {8'd0, SIN | SCLK | PCLK}, 32'd0);
      check("rst_hold_ack",  {31'd0, rif.user_ack}, 32'd0);
    end
    rst_n_i = 1'b1;
    tick();
    check("post_rst_ack", {31'd0, rif.user_ack}, 32'd0);
    rif.user_word = 24'h00A5A5;
    rif.user_req  = 1'b1;
    wait_check(1'b0, 1, 24'h00A5A5, 12'h004, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
